n_countdown_timer: RTL and testbench
====================================

// Module: n_countdown_timer
//
// PURPOSE
//   Programmable down-counting interval timer for the drum machine tempo path.
//   Loads a period P, counts P-1 down to 0 and emits a one-cycle tick_o on
//   every expiry. The timer then reloads (free-run) or stops (one-shot).
//   Its ticks drive the step counter's enable. This block is the
//   count-down/producer end of the step-advance interface.
//
// PARAMETERS
//   WIDTH   16   width of period_i and count_o, in bits
//
// PORTS
//   clk          in   1      single clock; all state changes on posedge clk
//   rst_n        in   1      reset: asynchronous, active-low
//   start_i      in   1      pulse: load period_i and enter RUN (restarts if running)
//   stop_i       in   1      pulse: abort to IDLE
//   pause_i      in   1      level: freeze count while high (RUN only)
//   one_shot_i   in   1      sampled at start: 1 = stop after first tick, 0 = reload
//   period_i     in   WIDTH  tick period in clk cycles; 0 is illegal
//   count_o      out  WIDTH  current remaining count (registered)
//   tick_o       out  1      one-cycle expiry pulse (registered)
//   busy_o       out  1      high in RUN or PAUSED
//   err_o        out  1      one-cycle pulse: start_i with period_i==0 was rejected
//
// BEHAVIOUR
// - Reset (rst_n low, async): state=IDLE, count_o=0, tick_o=0, busy_o=0,
//   err_o=0, latched one-shot flag=0.
// - tick_o and err_o default to 0 every cycle unless set below.
// - Event priority per edge: stop_i > start_i > pause_i > count.
// - IDLE: count_o holds 0.
//     start_i && period_i!=0 -> count<=period_i-1, latch one_shot_i, RUN.
//     start_i && period_i==0 -> stay IDLE, err_o<=1.
// - RUN:
//     stop_i -> IDLE, count<=0, no tick.
//     start_i -> same as the IDLE start (reload or err). Without stop_i on a
//       zero period, an err in RUN forces IDLE.
//     pause_i -> PAUSED, count held.
//     count==0 -> tick_o<=1. If one-shot: IDLE with count 0. Otherwise
//       count<=period_i-1, reloading from the live period_i when
//       period_i!=0. If period_i==0 at reload: err_o<=1, go IDLE.
//     else -> count<=count-1.
// - PAUSED:
//     stop_i -> IDLE. start_i -> restart as above.
//     pause_i low -> RUN on the next edge, count unchanged. The decrement
//       resumes the following edge.
//     No tick is ever issued in PAUSED.
// - Timing: start_i sampled at edge k gives count_o=P-1 after k. The first
//   tick_o is high in the cycle after edge k+P. In free-run, ticks follow
//   every P cycles exactly.
// - P=1 free-run: count_o stays 0 and tick_o is high every cycle.
// - P=2^WIDTH-1 is the maximum. The decrement never underflows because
//   count==0 always reloads or stops.
// - Tempo changes: period_i is sampled only at start and at reload. A new
//   value takes effect from the next step; the in-flight count is untouched.
// - busy_o = (state!=IDLE), registered alongside state.
// - rst_n asserted mid-count: immediate return to reset values, no tick.
//
// TESTING
// - Reset then start_i, P=4, free-run -> count_o 3,2,1,0,3..; tick_o pulses
//   at 4-cycle spacing, first 4 cycles after start.
// - P=1 free-run -> tick_o high every cycle, count_o=0; stop_i -> tick_o=0
//   next cycle, busy_o=0.
// - one_shot_i=1, P=3 -> exactly one tick_o; then busy_o=0, count_o=0, no
//   further ticks for 20 cycles.
// - P=5; pause_i high at count_o=2 for 6 cycles -> count_o holds 2, no tick;
//   after release the tick arrives 3 cycles after the PAUSED->RUN edge.
// - start_i with period_i=0 in IDLE -> err_o one pulse, busy_o stays 0;
//   change period_i 4->6 mid-run -> next interval 4, following intervals 6.
// - rst_n low mid-count, asynchronously -> all outputs 0 with no clock
//   edge; simultaneous stop_i+start_i -> IDLE.

Source files
------------

// File: rtl/n_countdown_timer.sv
// n_countdown_timer: programmable down-counting interval timer.
// Loads a period P, counts P-1 down to 0 and pulses o_tick on each expiry,
// then either reloads from the live period (free-run) or stops (one-shot).
module n_countdown_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             one_shot_i,
    input  logic [WIDTH-1:0] period_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_busy;
    logic             r_err;
    logic             r_one_shot;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tick_nxt;
    logic             w_err_nxt;
    logic             w_one_shot_nxt;
    logic             w_period_zero;
    logic [WIDTH-1:0] w_reload;

    assign w_period_zero = (period_i == '0);
    assign w_reload      = period_i - WIDTH'(1);

    // State, count and registered pulse outputs; busy tracks the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_one_shot <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_tick     <= w_tick_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_err      <= w_err_nxt;
            r_one_shot <= w_one_shot_nxt;
        end
    end

    // Next-state logic with priority stop > start > pause > count
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_tick_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_one_shot_nxt = r_one_shot;

        if (stop_i) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if (start_i) begin
            if (!w_period_zero) begin
                w_state_nxt    = S_RUN;
                w_count_nxt    = w_reload;
                w_one_shot_nxt = one_shot_i;
            end else begin
                // A rejected start also aborts any count in flight
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
                w_err_nxt   = 1'b1;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (pause_i) begin
                        w_state_nxt = S_PAUSED;
                    end else if (r_count == '0) begin
                        w_tick_nxt = 1'b1;
                        if (r_one_shot) begin
                            w_state_nxt = S_IDLE;
                            w_count_nxt = '0;
                        end else if (!w_period_zero) begin
                            w_count_nxt = w_reload;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_count_nxt = '0;
                            w_err_nxt   = 1'b1;
                        end
                    end else begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
                S_PAUSED: begin
                    if (!pause_i) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign count_o = r_count;
    assign tick_o  = r_tick;
    assign busy_o  = r_busy;
    assign err_o   = r_err;

endmodule

// File: tb/tb_n_countdown_timer.sv
// Directed bench for n_countdown_timer with hand-computed expectations.
module tb_n_countdown_timer;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic             stop_i;
    logic             pause_i;
    logic             one_shot_i;
    logic [WIDTH-1:0] period_i;
    logic [WIDTH-1:0] count_o;
    logic             tick_o;
    logic             busy_o;
    logic             err_o;

    int errors = 0;
    int checks = 0;

    n_countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .pause_i    (pause_i),
        .one_shot_i (one_shot_i),
        .period_i   (period_i),
        .count_o    (count_o),
        .tick_o     (tick_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        pause_i    = 1'b0;
        one_shot_i = 1'b0;
        period_i   = '0;

        // Reset values before any clock edge
        #2;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_tick",  32'(tick_o),  32'd0);
        chk("rst_busy",  32'(busy_o),  32'd0);
        chk("rst_err",   32'(err_o),   32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // P=4 free-run: 3,2,1,0,3... with ticks every 4 cycles
        period_i = 16'd4;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        chk("p4_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            chk("p4_count", 32'(count_o), 32'(3 - (i % 4)));
            chk("p4_tick",  32'(tick_o),  32'((i % 4 == 0) && (i > 0)));
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("p4_stop_busy",  32'(busy_o),  32'd0);
        chk("p4_stop_count", 32'(count_o), 32'd0);

        // P=1 free-run: tick every cycle, count stays 0
        period_i = 16'd1;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        chk("p1_count0", 32'(count_o), 32'd0);
        chk("p1_tick0",  32'(tick_o),  32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p1_tick",  32'(tick_o),  32'd1);
            chk("p1_count", 32'(count_o), 32'd0);
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("p1_stop_tick", 32'(tick_o), 32'd0);
        chk("p1_stop_busy", 32'(busy_o), 32'd0);

        // One-shot P=3: one tick, then idle; one_shot_i dropped after start
        period_i   = 16'd3;
        one_shot_i = 1'b1;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
        one_shot_i = 1'b0;
        chk("os_count2", 32'(count_o), 32'd2);
        step();
        chk("os_count1", 32'(count_o), 32'd1);
        step();
        chk("os_count0", 32'(count_o), 32'd0);
        chk("os_notick", 32'(tick_o),  32'd0);
        step();
        chk("os_tick",   32'(tick_o),  32'd1);
        chk("os_busy",   32'(busy_o),  32'd0);
        chk("os_count",  32'(count_o), 32'd0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick_o !== 1'b0 || busy_o !== 1'b0) ticks++;
        end
        chk("os_quiet", 32'(ticks), 32'd0);

        // P=5 with pause held at count 2 for 6 cycles
        period_i = 16'd5;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        chk("pz_count4", 32'(count_o), 32'd4);
        step();
        step();
        chk("pz_count2", 32'(count_o), 32'd2);
        pause_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("pz_hold", 32'(count_o), 32'd2);
            chk("pz_tick", 32'(tick_o),  32'd0);
            chk("pz_busy", 32'(busy_o),  32'd1);
        end
        pause_i = 1'b0;
        step();
        chk("pz_resume", 32'(count_o), 32'd2);
        step();
        chk("pz_dec1",   32'(count_o), 32'd1);
        step();
        chk("pz_dec0",   32'(count_o), 32'd0);
        chk("pz_notick", 32'(tick_o),  32'd0);
        step();
        chk("pz_tick_after", 32'(tick_o),  32'd1);
        chk("pz_reload",     32'(count_o), 32'd4);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;

        // Zero-period start in IDLE is rejected with a one-cycle err
        period_i = '0;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        chk("z_err",  32'(err_o),  32'd1);
        chk("z_busy", 32'(busy_o), 32'd0);
        step();
        chk("z_err_clr", 32'(err_o), 32'd0);

        // Period 4 -> 6 mid-run: ticks at +4, +10, +16
        period_i = 16'd4;
        start_i  = 1'b1;
        step();
        start_i  = 1'b0;
        period_i = 16'd6;
        chk("tc_count3", 32'(count_o), 32'd3);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("tc_tick", 32'(tick_o), 32'((i == 4) || (i == 10) || (i == 16)));
            chk("tc_count", 32'(count_o), (i < 4) ? 32'(3 - i) : 32'(5 - ((i - 4) % 6)));
        end

        // Zero-period restart while running forces IDLE with err
        period_i = '0;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        chk("zr_err",   32'(err_o),   32'd1);
        chk("zr_busy",  32'(busy_o),  32'd0);
        chk("zr_count", 32'(count_o), 32'd0);

        // Simultaneous stop and start while running -> IDLE
        period_i = 16'd7;
        start_i  = 1'b1;
        step();
        chk("ss_run", 32'(count_o), 32'd6);
        stop_i = 1'b1;
        step();
        stop_i  = 1'b0;
        start_i = 1'b0;
        chk("ss_busy",  32'(busy_o),  32'd0);
        chk("ss_count", 32'(count_o), 32'd0);

        // Asynchronous reset mid-count clears a nonzero count without an edge
        period_i = 16'd9;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("ar_pre", 32'(count_o), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(count_o), 32'd0);
        chk("ar_busy",  32'(busy_o),  32'd0);
        rst_n = 1'b1;
        step();

        // Asynchronous reset while tick is high clears it immediately
        period_i = 16'd1;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("ar2_pre_tick", 32'(tick_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar2_tick", 32'(tick_o), 32'd0);
        chk("ar2_busy", 32'(busy_o), 32'd0);
        chk("ar2_err",  32'(err_o),  32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
